// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader
//   state_t        : loader FSM states
//   WIDTH/DEPTH    : default word width (bits) and memory depth (words)
//   ADDR_WIDTH     : default write address width
//   BYTES_PER_WORD : stream bytes packed into one word
//   BCNT_W         : width of the in-word byte counter
package imem_loader_pkg;
    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int ADDR_WIDTH = 8;
    localparam int BYTES_PER_WORD = WIDTH / 8;
    localparam int BCNT_W = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: control, byte handshake and memory write signals of the loader
//   start/num_words         : load request and image length in words
//   byte_valid/byte_data    : byte source side of the handshake
//   byte_ready              : loader accepts a byte this cycle
//   A/WD/WE                 : synchronous memory write port
//   cpu_hold/done/err       : core hold, image complete, illegal length
//   master drives requests and bytes; slave is the loader
interface imem_loader_if #(
    parameter int Width     = 32,
    parameter int AddrWidth = 8
);
    logic                 start;
    logic [AddrWidth:0]   num_words;
    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 byte_ready;
    logic [AddrWidth-1:0] A;
    logic [Width-1:0]     WD;
    logic                 WE;
    logic                 cpu_hold;
    logic                 done;
    logic                 err;
    modport master (
        output start, num_words, byte_valid, byte_data,
        input  byte_ready, A, WD, WE, cpu_hold, done, err
    );
    modport slave (
        input  start, num_words, byte_valid, byte_data,
        output byte_ready, A, WD, WE, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer: assembles little-endian bytes into a word and tracks the byte position
//   clk, reset : clock and asynchronous active-high reset
//   strobe_i   : a byte transfers at this edge
//   clear_i    : restart at byte 0
//   byte_i     : stream byte
//   word_o     : assembled word including the byte currently offered
//   last_o     : the current byte position is the final lane of the word
module word_packer
    import imem_loader_pkg::*;
#(
    parameter int Width = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe_i,
    input  logic             clear_i,
    input  logic [7:0]       byte_i,
    output logic [Width-1:0] word_o,
    output logic             last_o
);
    localparam int Bpw = Width / 8;
    localparam int Cw = Bpw > 1 ? $clog2(Bpw) : 1;
    logic [Cw-1:0]    cnt_q, cnt_d;
    logic [Width-1:0] acc_q;
    // word_o already carries the incoming byte so the last byte can be latched in the same edge
    always_comb begin
        word_o = acc_q;
        word_o[{cnt_q, 3'b000} +: 8] = byte_i;
    end
    assign last_o = cnt_q == Cw'(Bpw - 1);
    assign cnt_d = clear_i ? '0 : !strobe_i ? cnt_q : last_o ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (strobe_i) acc_q <= word_o;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into words, writes them to instruction memory and holds the core meanwhile
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of imem_loader_if (request, byte handshake, write port, status)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int Width     = WIDTH,
    parameter int Depth     = DEPTH,
    parameter int AddrWidth = ADDR_WIDTH
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam logic [AddrWidth:0] DepthW = (AddrWidth + 1)'(Depth);
    state_t               state_q;
    logic                 ready_q, we_q, hold_q, done_q, err_q;
    logic [AddrWidth-1:0] a_q;
    logic [Width-1:0]     wd_q, word;
    logic [AddrWidth:0]   widx_q, nw_q;
    logic                 go, bad, xfer, last;
    assign go = bus.start && (state_q == IDLE || state_q == DONE);
    assign bad = bus.num_words == '0 || bus.num_words > DepthW;
    // ready is only ever high in LOAD, so a transfer implies LOAD
    assign xfer = bus.byte_valid && ready_q;
    word_packer #(.Width(Width)) u_packer (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (xfer),
        .clear_i  (go),
        .byte_i   (bus.byte_data),
        .word_o   (word),
        .last_o   (last)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            widx_q  <= '0;
            nw_q    <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (go) begin
                    if (bad) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= LOAD;
                        nw_q    <= bus.num_words;
                        widx_q  <= '0;
                        err_q   <= 1'b0;
                        done_q  <= 1'b0;
                        hold_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                LOAD: if (xfer && last) begin
                    state_q <= WRITE;
                    ready_q <= 1'b0;
                    we_q    <= 1'b1;
                    a_q     <= widx_q[AddrWidth-1:0];
                    wd_q    <= word;
                end
                WRITE: if (widx_q == nw_q - 1'b1) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    hold_q  <= 1'b0;
                end else begin
                    state_q <= LOAD;
                    widx_q  <= widx_q + 1'b1;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.byte_ready = ready_q;
    assign bus.A = a_q;
    assign bus.WD = wd_q;
    assign bus.WE = we_q;
    assign bus.cpu_hold = hold_q;
    assign bus.done = done_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized checks of imem_loader against a word/memory reference model
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    imem_loader_if #(.Width(32), .AddrWidth(8)) bus ();
    imem_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    int checks = 0;
    int failures = 0;
    int viol = 0;
    int edges;
    logic [7:0]  stream[$];
    logic [7:0]  wr_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] mem[256];
    logic        d1, h1;
    always @(posedge clk) begin
        if (bus.WE) begin
            wr_a.push_back(bus.A);
            wr_d.push_back(bus.WD);
            mem[bus.A] <= bus.WD;
            if (bus.byte_valid && bus.byte_ready) viol++;
        end
    end
    function automatic logic [31:0] exp_word(input int j);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++) w += 32'(stream[4*j+k]) * (32'd1 << (8 * k));
        return w;
    endfunction
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic run_load(input int n, input bit gaps, input int stop_at, input bit poke, output int e);
        int idx = 0;
        bit xfer;
        bit first = 1'b1;
        e = 0;
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_words = 9'(n);
        bus.byte_valid = 1'b0;
        @(posedge clk);
        e++;
        forever begin
            @(negedge clk);
            bus.start = 1'b0;
            if (first) begin
                d1 = bus.done;
                h1 = bus.cpu_hold;
                first = 1'b0;
            end
            if (bus.done || idx == stop_at || e > 3000) break;
            if (poke && idx == 2) begin
                bus.start = 1'b1;
                bus.num_words = 9'd3;
            end
            bus.byte_valid = idx < stream.size() && (!gaps || $urandom_range(0, 1) == 1);
            bus.byte_data = idx < stream.size() ? stream[idx] : 8'h00;
            xfer = bus.byte_valid && bus.byte_ready;
            @(posedge clk);
            e++;
            if (xfer) idx++;
        end
        bus.byte_valid = 1'b0;
        bus.start = 1'b0;
        check("load_terminates", 64'(e <= 3000), 64'd1);
    endtask
    task automatic check_writes(input string tag, input int n);
        check({tag, "_count"}, 64'(wr_a.size()), 64'(n));
        for (int j = 0; j < n && j < wr_a.size(); j++) begin
            check({tag, "_addr"}, 64'(wr_a[j]), 64'(j));
            check({tag, "_data"}, 64'(wr_d[j]), 64'(exp_word(j)));
        end
    endtask
    initial begin
        bus.start = 1'b0;
        bus.num_words = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_A", 64'(bus.A), 64'd0);
        check("rst_WD", 64'(bus.WD), 64'd0);
        check("rst_WE", 64'(bus.WE), 64'd0);
        check("rst_hold", 64'(bus.cpu_hold), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        reset = 1'b0;
        stream = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, 1'b0, -1, 1'b0, edges);
        check("basic_cycles", 64'(edges), 64'd11);
        check_writes("basic", 2);
        if (wr_d.size() == 2) begin
            check("basic_word0", 64'(wr_d[0]), 64'h12345678);
            check("basic_word1", 64'(wr_d[1]), 64'hDEADBEEF);
        end
        check("basic_done", 64'(bus.done), 64'd1);
        check("basic_hold", 64'(bus.cpu_hold), 64'd0);
        check("basic_err", 64'(bus.err), 64'd0);
        run_load(2, 1'b1, -1, 1'b0, edges);
        check_writes("gaps", 2);
        for (int r = 0; r < 3; r++) begin
            stream.delete();
            for (int i = 0; i < 20; i++) stream.push_back(8'($urandom));
            run_load(5, 1'b1, -1, 1'b0, edges);
            check_writes("rand", 5);
        end
        check("no_accept_during_we", 64'(viol), 64'd0);
        run_load(0, 1'b0, -1, 1'b0, edges);
        check("zero_cycles", 64'(edges), 64'd1);
        check("zero_done", 64'(d1), 64'd1);
        check("zero_err", 64'(bus.err), 64'd1);
        check("zero_writes", 64'(wr_a.size()), 64'd0);
        stream = {8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 1'b0, -1, 1'b0, edges);
        check("legal_clears_err", 64'(bus.err), 64'd0);
        run_load(257, 1'b0, -1, 1'b0, edges);
        check("big_cycles", 64'(edges), 64'd1);
        check("big_done", 64'(d1), 64'd1);
        check("big_err", 64'(bus.err), 64'd1);
        check("big_writes", 64'(wr_a.size()), 64'd0);
        stream.delete();
        for (int i = 0; i < 1024; i++) stream.push_back(8'(i));
        run_load(256, 1'b0, -1, 1'b0, edges);
        check("full_cycles", 64'(edges), 64'd1281);
        check_writes("full", 256);
        for (int i = 0; i < 256; i++) check("full_mem", 64'(mem[i]), 64'(exp_word(i)));
        check("full_done", 64'(bus.done), 64'd1);
        stream.delete();
        for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
        run_load(2, 1'b0, 6, 1'b0, edges);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(bus.byte_ready), 64'd0);
        check("mid_rst_A", 64'(bus.A), 64'd0);
        check("mid_rst_WD", 64'(bus.WD), 64'd0);
        check("mid_rst_WE", 64'(bus.WE), 64'd0);
        check("mid_rst_hold", 64'(bus.cpu_hold), 64'd1);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        check_writes("mid_rst_pre", 1);
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
        run_load(1, 1'b0, -1, 1'b0, edges);
        check_writes("after_rst", 1);
        check("after_rst_done", 64'(bus.done), 64'd1);
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
        run_load(1, 1'b0, -1, 1'b1, edges);
        check("restart_done_drop", 64'(d1), 64'd0);
        check("restart_hold_rise", 64'(h1), 64'd1);
        check("restart_cycles", 64'(edges), 64'd6);
        check_writes("restart", 1);
        check("restart_done", 64'(bus.done), 64'd1);
        check("restart_hold", 64'(bus.cpu_hold), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Writes program images into the instruction memory before the core runs. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into words, and issues one single-cycle write per word on a synchronous memory write port. The block holds the core in reset until the image is complete, then asserts `done`. It sits between the boot/debug byte source and the write side of the instruction memory; the core's fetch path keeps its combinational read port.

## Interface
- `Width`, 32: word width in bits; must be a multiple of 8.
- `Depth`, 256: memory depth in words.
- `AddrWidth`, 8: write address width; 2^AddrWidth ≥ Depth.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle load request; sampled only in IDLE or DONE.
- `num_words`  in  AddrWidth+1  number of words to load; sampled with `start`.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `A`  out  AddrWidth  memory write word address.
- `WD`  out  Width  memory write data.
- `WE`  out  1  memory write enable; memory writes `WD` to `A` at the rising edge where `WE`=1.
- `cpu_hold`  out  1  holds the core in reset.
- `done`  out  1  image fully written.
- `err`  out  1  the last `start` had an illegal `num_words`.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- Reset values: state IDLE, `byte_ready`=0, `A`=0, `WD`=0, `WE`=0, `cpu_hold`=1, `done`=0, `err`=0, byte counter 0, word index 0.
- IDLE, with `start`=1:
  - If `num_words` is 0 or greater than `Depth`: go to DONE, set `err`=1, no writes.
  - Otherwise: latch `num_words`, clear `err`, word index := 0, byte counter := 0, go to LOAD.
- LOAD:
  - `byte_ready`=1.
  - A byte transfers at an edge where `byte_valid`=`byte_ready`=1.
  - Byte k (k=0..Width/8-1) goes to `WD[8k+7:8k]`; the byte counter increments.
  - On the transfer of byte Width/8-1: byte counter := 0, go to WRITE.
- WRITE:
  - Lasts exactly one cycle. `WE`=1, `byte_ready`=0, `A`=word index, `WD`=packed word.
  - At the exit edge: if word index = `num_words`-1, go to DONE; else word index increments and go to LOAD.
- DONE:
  - `done`=1, `cpu_hold`=0.
  - `start`=1 restarts exactly as in IDLE: `done` falls, `cpu_hold` rises, `err` is re-evaluated.
- `cpu_hold` = 1 in IDLE, LOAD, WRITE.
- `start` is ignored in LOAD and WRITE.
- `byte_valid` while `byte_ready`=0: no transfer; the source must hold the byte.
- `A` and `WD` are registered and stable throughout WRITE. `WD` holds its last value outside WRITE; `WE`=0 outside WRITE.
- Address arithmetic: word index is AddrWidth+1 bits internally; `A` is its low AddrWidth bits. With `num_words`=`Depth`, the last write is at `Depth`-1 and never wraps.
- Reset mid-load: return to IDLE immediately and discard the partial word. Words already written stay in memory.

## Timing
- Byte accept to next byte accept: minimum 1 cycle within a word.
- Last byte of a word accepted at edge t: `WE`=1 during cycle t..t+1; memory write at edge t+1; `byte_ready` returns at t+1.
- Steady-state throughput: Width/8+1 cycles per word (5 at Width=32).
- `done` rises at the edge that commits the final write.
- Illegal `num_words`: `done` and `err` are both 1 one cycle after `start`.
- Total load time with continuous `byte_valid`: 1 + `num_words`·(Width/8+1) cycles from `start`.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum {IDLE, LOAD, WRITE, DONE}
  - `BYTES_PER_WORD` = Width/8
  - byte-counter width localparam
- Sub-module `word_packer`:
  - Inputs: `clk`, `reset`, byte strobe, `byte_data`, clear.
  - Outputs: packed word, last-byte flag.
  - Holds the byte counter and the `WD` assembly register.
- Top level holds the FSM, word index, `num_words` latch and output decode.

## Test plan
- Basic load: `num_words`=2, continuous bytes 78 56 34 12 EF BE AD DE.
  - Writes `A`=0 `WD`=0x12345678, then `A`=1 `WD`=0xDEADBEEF.
  - `WE` high exactly 2 cycles; `done` at cycle 11 after `start`; `cpu_hold` low after.
- Backpressure and gaps: `byte_valid` toggled randomly over the same stream.
  - Identical writes.
  - No byte is accepted while `WE`=1.
- Illegal length: `num_words`=0, then `num_words`=257.
  - Each gives `err`=1, `done`=1 one cycle after `start`; `WE` never asserts.
- Full depth: `num_words`=256 with an incrementing pattern.
  - 256 writes at addresses 0..255 in order; no wrap.
  - Memory read-back matches.
- Reset mid-word: assert `reset` after 2 bytes of word 1.
  - All outputs return to reset values the same cycle; no write for word 1.
  - A new `start` reloads correctly from `A`=0.
- Restart from DONE: `start` with `num_words`=1.
  - `done` drops and `cpu_hold` rises on the next edge; one write at `A`=0.
  - `start` pulsed during LOAD is ignored.
